// File: rtl/mips_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: op codes, FSM states
// and the lane/alignment helpers used by both the FSM and the align datapath.
package mips_lsu_pkg;

   typedef enum logic [2:0] {
      LSU_LB  = 3'd0,
      LSU_LBU = 3'd1,
      LSU_LH  = 3'd2,
      LSU_LHU = 3'd3,
      LSU_LW  = 3'd4,
      LSU_SB  = 3'd5,
      LSU_SH  = 3'd6,
      LSU_SW  = 3'd7
   } lsu_op_e;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOAD_WAIT = 2'd1,
      RMW_WAIT  = 2'd2,
      RMW_WRITE = 2'd3
   } lsu_state_e;

   function automatic logic is_misaligned(lsu_op_e op, logic [1:0] off);
      case (op)
         LSU_LH, LSU_LHU, LSU_SH: return off[0];
         LSU_LW, LSU_SW:          return (off != 2'd0);
         default:                 return 1'b0;
      endcase
   endfunction

   function automatic logic is_load(lsu_op_e op);
      return (op == LSU_LB) || (op == LSU_LBU) || (op == LSU_LH) ||
             (op == LSU_LHU) || (op == LSU_LW);
   endfunction

   // Big-endian mirrors the byte lane; halfword lanes reuse bit 1 of it.
   function automatic logic [1:0] byte_lane(logic [1:0] off, logic big_endian);
      return big_endian ? (2'd3 - off) : off;
   endfunction

endpackage

// File: rtl/mips_lsu_if.sv
// Word-wide port between the load/store unit (master) and the data SRAM (slave).
// Protocol: no handshake; a write commits on the edge ending a cycle with we=1,
// and read data for data_addr appears on ld_data in the following cycle.
interface mips_lsu_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic                  we;
   logic [DATA_WIDTH-1:0] st_data;
   logic [ADDR_WIDTH-1:0] data_addr;
   logic [DATA_WIDTH-1:0] ld_data;

   modport master (output we, output st_data, output data_addr, input ld_data);
   modport slave  (input we, input st_data, input data_addr, output ld_data);
endinterface

// File: rtl/mips_lsu_align.sv
// Combinational lane datapath: extracts/extends sub-word loads and merges
// byte/halfword store data into a read word for read-modify-write.
module lsu_align
   import mips_lsu_pkg::*;
#(
   parameter int BIG_ENDIAN = 0
) (
   input  lsu_op_e     op,
   input  logic [1:0]  offset,
   input  logic [31:0] word,
   input  logic [15:0] st_data,
   output logic [31:0] ld_ext,
   output logic [31:0] merged_word
);
   logic [1:0]  lane;
   logic [4:0]  bsh;
   logic [4:0]  hsh;
   logic [7:0]  b;
   logic [15:0] h;

   always_comb begin
      lane = byte_lane(offset, BIG_ENDIAN != 0);
      bsh  = {lane, 3'b000};
      hsh  = {lane[1], 4'b0000};
      b    = word[bsh +: 8];
      h    = word[hsh +: 16];

      ld_ext = word;
      case (op)
         LSU_LB:  ld_ext = {{24{b[7]}}, b};
         LSU_LBU: ld_ext = {24'd0, b};
         LSU_LH:  ld_ext = {{16{h[15]}}, h};
         LSU_LHU: ld_ext = {16'd0, h};
         default: ld_ext = word;
      endcase

      merged_word = word;
      case (op)
         LSU_SB:  merged_word[bsh +: 8]  = st_data[7:0];
         LSU_SH:  merged_word[hsh +: 16] = st_data;
         default: merged_word = word;
      endcase
   end
endmodule

// File: rtl/mips_lsu.sv
// MEM-stage load/store unit: word-aligned SRAM accesses, sub-word load
// extension, SB/SH via read-modify-write, misalignment reporting and stall.
module mips_lsu
   import mips_lsu_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int BIG_ENDIAN = 0
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_req,
   input  logic [2:0]            i_op,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [DATA_WIDTH-1:0] i_st_data,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [DATA_WIDTH-1:0] o_ld_data,
   output logic                  o_misalign,
   output logic [ADDR_WIDTH-1:0] o_bad_addr,
   output lsu_state_e            o_state,
   mips_lsu_if.master            bus
);
   lsu_state_e            state, state_d;
   lsu_op_e               req_op, op_q, op_d;
   logic [1:0]            off_q, off_d;
   logic [ADDR_WIDTH-3:0] wa_q, wa_d;
   logic [15:0]           sd_q, sd_d;
   logic [DATA_WIDTH-1:0] merged_q, merged_d;
   logic [DATA_WIDTH-1:0] ld_d, ld_ext, merged_word;
   logic                  done_d, mis_d;
   logic [ADDR_WIDTH-1:0] bad_d;
   logic                  we;
   logic [DATA_WIDTH-1:0] st;
   logic [ADDR_WIDTH-1:0] daddr;

   assign req_op = lsu_op_e'(i_op);

   lsu_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_align (
      .op          (op_q),
      .offset      (off_q),
      .word        (bus.ld_data),
      .st_data     (sd_q),
      .ld_ext      (ld_ext),
      .merged_word (merged_word)
   );

   always_comb begin
      state_d  = state;
      op_d     = op_q;
      off_d    = off_q;
      wa_d     = wa_q;
      sd_d     = sd_q;
      merged_d = merged_q;
      done_d   = 1'b0;
      mis_d    = 1'b0;
      ld_d     = o_ld_data;
      bad_d    = o_bad_addr;
      we       = 1'b0;
      st       = '0;
      daddr    = {wa_q, 2'b00};
      case (state)
         IDLE: begin
            daddr = {i_addr[ADDR_WIDTH-1:2], 2'b00};
            if (i_req) begin
               if (is_misaligned(req_op, i_addr[1:0])) begin
                  done_d = 1'b1;
                  mis_d  = 1'b1;
                  ld_d   = '0;
                  bad_d  = i_addr;
               end else if (req_op == LSU_SW) begin
                  we     = 1'b1;
                  st     = i_st_data;
                  done_d = 1'b1;
               end else begin
                  op_d    = req_op;
                  off_d   = i_addr[1:0];
                  wa_d    = i_addr[ADDR_WIDTH-1:2];
                  sd_d    = i_st_data[15:0];
                  state_d = is_load(req_op) ? LOAD_WAIT : RMW_WAIT;
               end
            end
         end
         LOAD_WAIT: begin
            ld_d    = ld_ext;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         RMW_WAIT: begin
            merged_d = merged_word;
            state_d  = RMW_WRITE;
         end
         RMW_WRITE: begin
            we      = 1'b1;
            st      = merged_q;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state      <= IDLE;
         op_q       <= LSU_LB;
         off_q      <= '0;
         wa_q       <= '0;
         sd_q       <= '0;
         merged_q   <= '0;
         o_done     <= 1'b0;
         o_misalign <= 1'b0;
         o_ld_data  <= '0;
         o_bad_addr <= '0;
      end else begin
         state      <= state_d;
         op_q       <= op_d;
         off_q      <= off_d;
         wa_q       <= wa_d;
         sd_q       <= sd_d;
         merged_q   <= merged_d;
         o_done     <= done_d;
         o_misalign <= mis_d;
         o_ld_data  <= ld_d;
         o_bad_addr <= bad_d;
      end
   end

   // Bus outputs are forced quiet while reset is asserted, even mid-RMW.
   assign bus.we        = we & i_rst_n;
   assign bus.st_data   = i_rst_n ? st : '0;
   assign bus.data_addr = i_rst_n ? daddr : '0;
   assign o_busy        = (state != IDLE);
   assign o_state       = state;
endmodule
